// File: rtl/ser_key_seq_ctrl.sv
// Serial key sequencer: resets the device, then clocks it N steps
// while shifting the SDRD response of each step into a result word.
module ser_key_seq_ctrl #(
  parameter int MAX_BITS  = 16,
  parameter int SETUP_CYC = 2,
  parameter int STRB_CYC  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4:0]          nbits,
  input  logic [3:0]          nib,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [MAX_BITS-1:0] result,
  output logic                dev_sser_n,
  output logic                dev_ba13,
  output logic                dev_ba12,
  output logic [3:0]          dev_nib,
  output logic                dev_br_w,
  output logic                dev_strb,
  input  logic                dev_sdrd
);

  localparam int IW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam logic [4:0] MAXB = 5'(MAX_BITS);
  localparam logic [7:0] DRST_LAST = 8'(STRB_CYC);
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STRB_LAST = 8'(STRB_CYC - 1);
  localparam logic [7:0] STRB_LEN = 8'(STRB_CYC);

  typedef enum logic [2:0] {
    IDLE, DRST, SETUP, SAMPLE, STRB, FIN
  } state_t;

  state_t st, st_d;
  logic [7:0] cnt, cnt_d;
  logic [4:0] step, step_d;
  logic [4:0] nb_q, nb_d;
  logic [3:0] nib_q, nib_d;
  logic [3:0] dnib_q, dnib_d;
  logic win, win_d;
  logic strb, strb_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [MAX_BITS-1:0] res_q, res_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= IDLE;
      cnt    <= '0;
      step   <= '0;
      nb_q   <= '0;
      nib_q  <= '0;
      dnib_q <= '0;
      win    <= 1'b0;
      strb   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      st     <= st_d;
      cnt    <= cnt_d;
      step   <= step_d;
      nb_q   <= nb_d;
      nib_q  <= nib_d;
      dnib_q <= dnib_d;
      win    <= win_d;
      strb   <= strb_d;
      busy_q <= busy_d;
      done_q <= done_d;
      res_q  <= res_d;
    end
  end

  always_comb begin
    st_d   = st;
    cnt_d  = cnt;
    step_d = step;
    nb_d   = nb_q;
    nib_d  = nib_q;
    dnib_d = dnib_q;
    win_d  = win;
    strb_d = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;
    res_d  = res_q;
    case (st)
      IDLE: begin
        win_d = 1'b0;
        if (start) begin
          nib_d  = nib;
          nb_d   = (nbits == 5'd0 || nbits > MAXB) ? MAXB : nbits;
          res_d  = '0;
          step_d = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          strb_d = 1'b1;
          st_d   = DRST;
        end
      end
      DRST: begin
        if (cnt == DRST_LAST) begin
          cnt_d  = '0;
          win_d  = 1'b1;
          dnib_d = nib_q;
          st_d   = SETUP;
        end else begin
          cnt_d  = cnt + 8'd1;
          strb_d = (cnt + 8'd1) < STRB_LEN;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_d = '0;
          st_d  = SAMPLE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      SAMPLE: begin
        res_d[step[IW-1:0]] = dev_sdrd;
        step_d = step + 5'd1;
        cnt_d  = '0;
        strb_d = 1'b1;
        st_d   = STRB;
      end
      STRB: begin
        if (cnt == STRB_LAST) begin
          cnt_d = '0;
          if (step == nb_q) begin
            win_d  = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
            st_d   = FIN;
          end else begin
            st_d = SETUP;
          end
        end else begin
          cnt_d  = cnt + 8'd1;
          strb_d = 1'b1;
        end
      end
      FIN: st_d = IDLE;
      default: st_d = IDLE;
    endcase
    // abort drops the window with the strobe low and keeps partial bits
    if (abort && st != IDLE) begin
      st_d   = IDLE;
      cnt_d  = '0;
      step_d = step;
      strb_d = 1'b0;
      win_d  = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b0;
      res_d  = res_q;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = res_q;
  assign dev_sser_n = ~win;
  assign dev_ba13   = ~win;
  assign dev_ba12   = win;
  assign dev_br_w   = win;
  assign dev_nib    = dnib_q;
  assign dev_strb   = strb;

endmodule

// File: tb/tb_ser_key_seq_ctrl.sv
// Bench for ser_key_seq_ctrl: device model, scoreboard on done,
// pin timing monitor and directed abort/reset/busy-start cases.
module tb_ser_key_seq_ctrl;

  localparam int SETUP_CYC = 2;
  localparam int STRB_CYC  = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [4:0] nbits;
  logic [3:0] nib;
  logic abort;
  logic busy;
  logic done;
  logic [15:0] result;
  logic dev_sser_n;
  logic dev_ba13;
  logic dev_ba12;
  logic [3:0] dev_nib;
  logic dev_br_w;
  logic dev_strb;
  logic dev_sdrd;

  ser_key_seq_ctrl #(
    .MAX_BITS(16),
    .SETUP_CYC(SETUP_CYC),
    .STRB_CYC(STRB_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .nbits(nbits),
    .nib(nib),
    .abort(abort),
    .busy(busy),
    .done(done),
    .result(result),
    .dev_sser_n(dev_sser_n),
    .dev_ba13(dev_ba13),
    .dev_ba12(dev_ba12),
    .dev_nib(dev_nib),
    .dev_br_w(dev_br_w),
    .dev_strb(dev_strb),
    .dev_sdrd(dev_sdrd)
  );

  always #5 clk = ~clk;

  // device: DRST strobe clears the bit index, window strobes advance it
  logic [31:0] pat = '0;
  int widx = 0;
  always @(posedge dev_strb) begin
    if (dev_sser_n) widx = 0;
    else widx = widx + 1;
  end
  assign dev_sdrd = pat[widx[4:0]];

  typedef struct {
    logic [15:0] res;
    int lat;
    int nb;
  } exp_t;
  exp_t q[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor
  int cyc = 0;
  int t_start = 0;
  int drst_n = 0;
  int win_n = 0;
  int sel_low = 0;
  bit nib_bad = 0;
  bit first_seen = 0;
  bit first_idle = 0;
  logic [3:0] cur_nib = '0;
  logic p_strb = 0, p_sser = 1, p_ba12 = 0;
  logic [3:0] p_nib = '0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (start && !busy) begin
        t_start = cyc;
        drst_n = 0;
        win_n = 0;
        nib_bad = 0;
        first_seen = 0;
        cur_nib = nib;
      end
      if (dev_strb && !p_strb) begin
        chk("strb_vs_window",
            {29'd0, dev_sser_n != p_sser, dev_ba12 != p_ba12,
             dev_nib != p_nib}, 0);
        if (!first_seen) begin
          first_seen = 1;
          first_idle = dev_sser_n;
        end
        if (dev_sser_n) drst_n++;
        else begin
          win_n++;
          chk("setup_len", sel_low >= SETUP_CYC, 1);
        end
      end
      if (dev_sser_n || dev_strb) sel_low = 0;
      else sel_low++;
      if (!dev_sser_n && dev_nib !== cur_nib) nib_bad = 1;
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("latency", cyc - t_start + 1, e.lat);
          chk("drst_strobes", drst_n, 1);
          chk("win_strobes", win_n, e.nb);
          chk("drst_first", first_idle, 1);
          chk("nib_stable", nib_bad, 0);
          chk("busy_at_done", busy, 0);
        end
      end
    end
    p_strb = dev_strb;
    p_sser = dev_sser_n;
    p_ba12 = dev_ba12;
    p_nib = dev_nib;
  end

  task automatic issue(input logic [3:0] n, input logic [4:0] b,
                       input logic [31:0] p, input bit push,
                       input bit ab);
    exp_t e;
    int eb;
    logic [15:0] m;
    @(posedge clk); #1;
    pat = p;
    nib = n;
    nbits = b;
    start = 1;
    abort = ab;
    if (push) begin
      eb = (b == 0 || b > 16) ? 16 : int'(b);
      m = (eb == 16) ? 16'hFFFF : 16'((32'd1 << eb) - 1);
      e.res = p[15:0] & m;
      e.nb = eb;
      e.lat = 1 + (STRB_CYC + 1) + eb * (SETUP_CYC + 1 + STRB_CYC) + 1;
      q.push_back(e);
    end
    @(posedge clk); #1;
    start = 0;
    abort = 0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < budget);
    chk("idle_timeout", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    start = 1;
    nbits = 5'd4;
    nib = 4'h2;
    abort = 0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_busy", busy, 0);
    end
    chk("reset_pins",
        {done, dev_sser_n, dev_ba13, dev_ba12, dev_br_w, dev_strb, dev_nib},
        {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    chk("reset_result", result, 0);
    @(posedge clk); #1;
    start = 0;
    rst_n = 1;

    issue(4'h2, 5'd4, 32'hA5A5_A5FD, 1, 0);
    wait_idle(200);
    issue(4'h9, 5'd0, 32'h0001_B6E5, 1, 0);
    wait_idle(200);
    issue(4'h5, 5'd20, 32'h0000_7F3C, 1, 0);
    wait_idle(200);
    issue(4'hC, 5'd1, 32'h0000_0001, 1, 0);
    wait_idle(200);

    // start ignored while busy
    issue(4'h2, 5'd6, 32'h0000_0029, 1, 0);
    repeat (8) @(posedge clk);
    #1;
    nib = 4'hF;
    nbits = 5'd1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_idle(200);

    // abort during the third strobe
    issue(4'h7, 5'd8, 32'h0000_FFF3, 0, 0);
    begin
      int k = 0;
      do begin
        @(negedge clk); #1;
        k++;
      end while (!(dev_strb && !dev_sser_n && win_n == 3) && k < 100);
      chk("abort_wait", k < 100, 1);
    end
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_strb", dev_strb, 0);
    chk("abort_window", {dev_sser_n, dev_ba13, dev_ba12, dev_br_w}, 4'b1100);
    chk("abort_result", result, 16'h0003);
    repeat (6) @(negedge clk);
    issue(4'h3, 5'd3, 32'h0000_0006, 1, 0);
    wait_idle(200);

    // abort with start in IDLE: start wins
    issue(4'hA, 5'd2, 32'h0000_0002, 1, 1);
    wait_idle(200);

    // reset mid transaction
    issue(4'h4, 5'd5, 32'h0000_001F, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_pins", {dev_strb, dev_sser_n, dev_ba12, dev_nib},
        {1'b0, 1'b1, 1'b0, 4'h0});
    chk("midrst_result", result, 0);
    rst_n = 1;
    issue(4'h6, 5'd4, 32'h0000_000A, 1, 0);
    wait_idle(200);

    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
